key_lut_reg: RTL and testbench
==============================

# key_lut_reg

Runtime-programmable successor to the combinational key/data mux: an NR_KEY-entry table of (key, data) pairs held in registers, written through a write port and searched through a valid/ready lookup channel with a registered, back-pressurable result. It serves NPC decode and peripheral address-map logic where table contents change at run time or a registered lookup is needed to meet timing. Matching is priority-encoded (lowest index wins), so duplicate keys are deterministic.

## Interface
- NR_KEY, 4, number of table entries (≥1)
- KEY_LEN, 4, key width in bits
- DATA_LEN, 8, data width in bits
- HAS_DEFAULT, 1, 1: miss returns default_out; 0: miss returns 0
- IDX_W, $clog2(NR_KEY) (min 1), localparam, entry index width
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- wr_en  in  1  write entry wr_idx this cycle
- wr_idx  in  IDX_W  entry to write; values ≥ NR_KEY ignored
- wr_key  in  KEY_LEN  key written
- wr_data  in  DATA_LEN  data written
- clr  in  1  invalidate all entries
- lk_valid  in  1  lookup request valid
- lk_ready  out  1  lookup accepted when lk_valid & lk_ready
- lk_key  in  KEY_LEN  key to search
- default_out  in  DATA_LEN  miss value, sampled at accept
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_data  out  DATA_LEN  matched data or miss value
- res_hit  out  1  1 if any valid entry matched
- res_idx  out  IDX_W  index of winning entry; 0 on miss

## Operation
- Table: per entry key, data, valid bit. Write sets key/data and valid=1.
- clr clears all valid bits; key/data unchanged. clr and wr_en same cycle: clr wins, written entry ends invalid.
- Match: entry i matches when valid[i] & key[i]==lk_key. Winner = lowest matching index.
- Miss: res_data = HAS_DEFAULT ? default_out : 0; res_hit=0; res_idx=0.
- Lookup reads table contents before any same-cycle write/clr (old data).
- Output register, one slot: lk_ready = !res_valid | res_ready. Accept loads res_*, sets res_valid.
- res_valid & res_ready & no accept → res_valid=0. Accept in same cycle as drain → new result replaces old, res_valid stays 1 (full throughput).
- res_* held stable while res_valid & !res_ready.

## Timing
- Reset (rst_n=0 at edge): all valid bits 0, keys/data 0, res_valid=0, res_data=0, res_hit=0, res_idx=0; lk_ready=1 next cycle.
- Reset mid-operation discards pending result and all entries; lk_valid/wr_en ignored during reset cycle.
- Latency: lookup accepted at edge N → res_valid at N (visible after edge N), result of table state before edge N.
- Write at edge N visible to lookups accepted at edge N+1 onward.
- Throughput: one lookup per cycle with res_ready held high.

## Configuration
- KEY_LUT_MULTIHIT_EN defined: adds outputs res_multi (1 bit, registered with result, 1 when ≥2 valid entries matched) and multi_err (sticky, set on any accepted multi-match lookup, cleared by clr or reset; reset value 0).
- Not defined: ports absent; duplicate matches silently resolved by priority.

## Test plan
- Reset, then lookup key 0x3 with default_out=0xEE, HAS_DEFAULT=1 → next cycle res_valid=1, res_hit=0, res_data=0xEE, res_idx=0.
- Write idx1 (0x5,0xA1), idx3 (0x5,0xB2); lookup 0x5 → res_hit=1, res_data=0xA1, res_idx=1; with macro res_multi=1, multi_err=1.
- Write idx2 (0x7,0x42) and lookup 0x7 same cycle → miss; lookup 0x7 next cycle → hit, 0x42.
- Hold res_ready=0 three cycles after a result → lk_ready=0, res_* unchanged; raise res_ready with lk_valid → back-to-back results, res_valid never drops.
- clr with simultaneous write idx0 (0x1,0x11), then lookup 0x1 → miss; multi_err=0.
- Assert rst_n=0 while res_valid=1 and res_ready=0 → res_valid=0 after edge, all prior keys miss.

Source files
------------

// File: rtl/key_lut_reg.sv
// key_lut_reg: runtime-programmable (key, data) lookup table.
// NR_KEY entries are held in registers and written through a simple write port.
// Lookups use a valid/ready channel and return a registered result that the
// consumer can back-pressure. The lowest matching index wins.
// Optional feature macro: KEY_LUT_MULTIHIT_EN adds the res_multi and multi_err outputs.
module key_lut_reg #(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 4,
  parameter int DATA_LEN    = 8,
  parameter bit HAS_DEFAULT = 1'b1,
  localparam int IDX_W      = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                clr,
  input  logic                lk_valid,
  output logic                lk_ready,
  input  logic [KEY_LEN-1:0]  lk_key,
  input  logic [DATA_LEN-1:0] default_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_LEN-1:0] res_data,
  output logic                res_hit,
  output logic [IDX_W-1:0]    res_idx
`ifdef KEY_LUT_MULTIHIT_EN
  ,
  output logic                res_multi,
  output logic                multi_err
`endif
);

  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];
  logic [NR_KEY-1:0]   valid_q;

  logic                res_valid_q;
  logic [DATA_LEN-1:0] res_data_q;
  logic                res_hit_q;
  logic [IDX_W-1:0]    res_idx_q;

  logic [DATA_LEN-1:0] res_data_d;
  logic                res_hit_d;
  logic [IDX_W-1:0]    res_idx_d;

  logic                accept;

`ifdef KEY_LUT_MULTIHIT_EN
  logic                res_multi_q;
  logic                multi_err_q;
  logic                res_multi_d;
`endif

  // A new request is taken whenever the single output slot is empty or is being drained this cycle.
  assign lk_ready = !res_valid_q || res_ready;
  assign accept   = lk_valid && lk_ready;

  // Priority search over the table as it stood before this edge; scanning downwards lets the lowest index overwrite.
  always_comb begin
    res_hit_d  = 1'b0;
    res_idx_d  = '0;
    res_data_d = HAS_DEFAULT ? default_out : '0;
`ifdef KEY_LUT_MULTIHIT_EN
    res_multi_d = 1'b0;
`endif
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (valid_q[i] && (key_q[i] == lk_key)) begin
`ifdef KEY_LUT_MULTIHIT_EN
        if (res_hit_d) res_multi_d = 1'b1;
`endif
        res_hit_d  = 1'b1;
        res_idx_d  = IDX_W'(i);
        res_data_d = data_q[i];
      end
    end
  end

  // Table storage: clear takes priority over a same-cycle write; out-of-range indices never match an entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < NR_KEY; i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (clr) begin
      valid_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (int'(wr_idx) == i) begin
          key_q[i]   <= wr_key;
          data_q[i]  <= wr_data;
          valid_q[i] <= 1'b1;
        end
      end
    end
  end

  // Output slot: load on accept, empty on drain without a new accept, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_hit_q   <= 1'b0;
      res_idx_q   <= '0;
    end else if (accept) begin
      res_valid_q <= 1'b1;
      res_data_q  <= res_data_d;
      res_hit_q   <= res_hit_d;
      res_idx_q   <= res_idx_d;
    end else if (res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

`ifdef KEY_LUT_MULTIHIT_EN
  // Multi-hit flag travels with the result; the sticky error is cleared by clr ahead of any same-cycle set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_multi_q <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      if (accept) res_multi_q <= res_multi_d;
      if (clr) begin
        multi_err_q <= 1'b0;
      end else if (accept && res_multi_d) begin
        multi_err_q <= 1'b1;
      end
    end
  end

  assign res_multi = res_multi_q;
  assign multi_err = multi_err_q;
`endif

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_hit   = res_hit_q;
  assign res_idx   = res_idx_q;

endmodule

// File: tb/tb_key_lut_reg.sv
// Directed self-checking bench for key_lut_reg (default parameters, HAS_DEFAULT=1).
// Optional multi-hit checks are compiled in when KEY_LUT_MULTIHIT_EN is defined.
module tb_key_lut_reg;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [3:0] wr_key;
  logic [7:0] wr_data;
  logic       clr;
  logic       lk_valid;
  logic       lk_ready;
  logic [3:0] lk_key;
  logic [7:0] default_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_hit;
  logic [1:0] res_idx;
`ifdef KEY_LUT_MULTIHIT_EN
  logic       res_multi;
  logic       multi_err;
`endif

  int checks = 0;
  int errors = 0;

  key_lut_reg dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .clr(clr), .lk_valid(lk_valid), .lk_ready(lk_ready),
    .lk_key(lk_key), .default_out(default_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_hit(res_hit), .res_idx(res_idx)
`ifdef KEY_LUT_MULTIHIT_EN
    , .res_multi(res_multi), .multi_err(multi_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_key = '0; wr_data = '0; clr = 1'b0;
    lk_valid = 1'b0; lk_key = '0; default_out = 8'hEE; res_ready = 1'b0;
    tick(); tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h want 0", res_valid); end
    checks++; if (res_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %h want 0", res_hit); end
    checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", res_data); end
    checks++; if (res_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %h want 0", res_idx); end
    checks++; if (lk_ready !== 1'b1) begin errors++; $display("FAIL reset_lk_ready got %h want 1", lk_ready); end
`ifdef KEY_LUT_MULTIHIT_EN
    checks++; if (multi_err !== 1'b0) begin errors++; $display("FAIL reset_multi_err got %h want 0", multi_err); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_miss_default();
    res_ready = 1'b1; lk_valid = 1'b1; lk_key = 4'h3; default_out = 8'hEE;
    tick();
    lk_valid = 1'b0;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL miss_valid got %h want 1", res_valid); end
    checks++; if (res_hit !== 1'b0) begin errors++; $display("FAIL miss_hit got %h want 0", res_hit); end
    checks++; if (res_data !== 8'hEE) begin errors++; $display("FAIL miss_data got %h want EE", res_data); end
    checks++; if (res_idx !== 2'd0) begin errors++; $display("FAIL miss_idx got %h want 0", res_idx); end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %h want 0", res_valid); end
  endtask

  task automatic test_priority();
    wr_en = 1'b1; wr_idx = 2'd1; wr_key = 4'h5; wr_data = 8'hA1;
    tick();
    wr_idx = 2'd3; wr_key = 4'h5; wr_data = 8'hB2;
    tick();
    wr_en = 1'b0; lk_valid = 1'b1; lk_key = 4'h5;
    tick();
    lk_valid = 1'b0;
    checks++; if (res_hit !== 1'b1) begin errors++; $display("FAIL prio_hit got %h want 1", res_hit); end
    checks++; if (res_data !== 8'hA1) begin errors++; $display("FAIL prio_data got %h want A1", res_data); end
    checks++; if (res_idx !== 2'd1) begin errors++; $display("FAIL prio_idx got %h want 1", res_idx); end
`ifdef KEY_LUT_MULTIHIT_EN
    checks++; if (res_multi !== 1'b1) begin errors++; $display("FAIL prio_multi got %h want 1", res_multi); end
    checks++; if (multi_err !== 1'b1) begin errors++; $display("FAIL prio_multi_err got %h want 1", multi_err); end
`endif
    tick();
  endtask

  task automatic test_write_then_lookup();
    wr_en = 1'b1; wr_idx = 2'd2; wr_key = 4'h7; wr_data = 8'h42;
    lk_valid = 1'b1; lk_key = 4'h7;
    tick();
    wr_en = 1'b0;
    checks++; if (res_hit !== 1'b0) begin errors++; $display("FAIL samecyc_hit got %h want 0", res_hit); end
    checks++; if (res_data !== 8'hEE) begin errors++; $display("FAIL samecyc_data got %h want EE", res_data); end
    tick();
    lk_valid = 1'b0;
    checks++; if (res_hit !== 1'b1) begin errors++; $display("FAIL nextcyc_hit got %h want 1", res_hit); end
    checks++; if (res_data !== 8'h42) begin errors++; $display("FAIL nextcyc_data got %h want 42", res_data); end
    checks++; if (res_idx !== 2'd2) begin errors++; $display("FAIL nextcyc_idx got %h want 2", res_idx); end
  endtask

  task automatic test_back_to_back();
    // Slot holds the key-7 result; stall it with a pending request waiting.
    res_ready = 1'b0; lk_valid = 1'b1; lk_key = 4'h5;
    #1;
    checks++; if (lk_ready !== 1'b0) begin errors++; $display("FAIL stall_lk_ready got %h want 0", lk_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc %0d got %h want 1", c, res_valid); end
      checks++; if (res_data !== 8'h42) begin errors++; $display("FAIL stall_data cyc %0d got %h want 42", c, res_data); end
      checks++; if (res_idx !== 2'd2) begin errors++; $display("FAIL stall_idx cyc %0d got %h want 2", c, res_idx); end
      checks++; if (lk_ready !== 1'b0) begin errors++; $display("FAIL stall_ready cyc %0d got %h want 0", c, lk_ready); end
    end
    res_ready = 1'b1;
    #1;
    checks++; if (lk_ready !== 1'b1) begin errors++; $display("FAIL release_lk_ready got %h want 1", lk_ready); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 8'hA1 || res_idx !== 2'd1) begin errors++; $display("FAIL b2b_0 got v%h d%h i%h want v1 dA1 i1", res_valid, res_data, res_idx); end
    lk_key = 4'h7;
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 8'h42 || res_idx !== 2'd2) begin errors++; $display("FAIL b2b_1 got v%h d%h i%h want v1 d42 i2", res_valid, res_data, res_idx); end
    lk_key = 4'h3;
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 8'hEE || res_hit !== 1'b0) begin errors++; $display("FAIL b2b_2 got v%h d%h h%h want v1 dEE h0", res_valid, res_data, res_hit); end
    lk_valid = 1'b0;
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %h want 0", res_valid); end
  endtask

  task automatic test_clr();
    clr = 1'b1; wr_en = 1'b1; wr_idx = 2'd0; wr_key = 4'h1; wr_data = 8'h11;
    tick();
    clr = 1'b0; wr_en = 1'b0; lk_valid = 1'b1; lk_key = 4'h1;
    tick();
    checks++; if (res_hit !== 1'b0 || res_data !== 8'hEE) begin errors++; $display("FAIL clr_key1 got h%h d%h want h0 dEE", res_hit, res_data); end
`ifdef KEY_LUT_MULTIHIT_EN
    checks++; if (multi_err !== 1'b0) begin errors++; $display("FAIL clr_multi_err got %h want 0", multi_err); end
`endif
    lk_key = 4'h5;
    tick();
    lk_valid = 1'b0;
    checks++; if (res_hit !== 1'b0) begin errors++; $display("FAIL clr_key5 got %h want 0", res_hit); end
    tick();
  endtask

  task automatic test_reset_mid();
    wr_en = 1'b1; wr_idx = 2'd0; wr_key = 4'h9; wr_data = 8'h99;
    tick();
    wr_en = 1'b0; res_ready = 1'b0; lk_valid = 1'b1; lk_key = 4'h9;
    tick();
    checks++; if (res_valid !== 1'b1 || res_hit !== 1'b1 || res_data !== 8'h99) begin errors++; $display("FAIL pre_rst got v%h h%h d%h want v1 h1 d99", res_valid, res_hit, res_data); end
    rst_n = 1'b0; wr_en = 1'b1; wr_idx = 2'd1; wr_key = 4'h3; wr_data = 8'h33;
    tick();
    checks++; if (res_valid !== 1'b0 || res_data !== 8'h00) begin errors++; $display("FAIL mid_rst got v%h d%h want v0 d00", res_valid, res_data); end
    checks++; if (lk_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %h want 1", lk_ready); end
    rst_n = 1'b1; wr_en = 1'b0; res_ready = 1'b1; lk_key = 4'h9;
    tick();
    checks++; if (res_valid !== 1'b1 || res_hit !== 1'b0) begin errors++; $display("FAIL post_rst_key9 got v%h h%h want v1 h0", res_valid, res_hit); end
    lk_key = 4'h3;
    tick();
    checks++; if (res_hit !== 1'b0) begin errors++; $display("FAIL post_rst_key3 got %h want 0", res_hit); end
    lk_key = 4'h0;
    tick();
    lk_valid = 1'b0;
    checks++; if (res_hit !== 1'b0 || res_data !== 8'hEE) begin errors++; $display("FAIL post_rst_key0 got h%h d%h want h0 dEE", res_hit, res_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_miss_default();
    test_priority();
    test_write_then_lookup();
    test_back_to_back();
    test_clr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
